event_pending8: RTL and testbench

//   8-bit sticky event-pending register sitting directly upstream of Or8way.

---
 rtl/event_pending8.sv | 95 +++++++++
 tb/tb_event_pending8.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/event_pending8.sv
// Sticky 8-bit event-pending register with mask, lowest-index-first pending index and ack.
// Optional 2-flop input synchroniser enabled by defining PENDING_SYNC_EN.
module event_pending8 #(
  parameter bit         EDGE       = 1'b1,
  parameter logic [7:0] RESET_MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ev,
  input  logic       mask_we,
  input  logic [7:0] mask_in,
  input  logic [7:0] clr,
  input  logic       ack,
  output logic [7:0] pending,
  output logic [7:0] out,
  output logic [2:0] idx,
  output logic       valid
);

  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic [7:0] r_ev_prev;
  logic [7:0] w_ev_s;
  logic [7:0] w_set;
  logic [7:0] w_ack_clr;
  logic [7:0] w_clr;
  logic [7:0] w_out;
  logic [2:0] w_idx;
  logic       w_valid;

`ifdef PENDING_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= ev;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ev_s = r_sync2;
`else
  assign w_ev_s = ev;
`endif

  // ev_prev resets to 0, so an input already high at reset release reads as an edge.
  always_comb begin
    w_set = 8'h00;
    if (EDGE) w_set = w_ev_s & ~r_ev_prev;
    else      w_set = w_ev_s;
  end

  assign w_out = r_pending & r_mask;

  always_comb begin
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_out[i]) w_idx = 3'(i);
    end
  end

  assign w_valid = |w_out;

  // Handshake: idx is meaningful only while valid=1; ack consumes that bit at the
  // same edge and is ignored while valid=0. No back-pressure on the event side.
  always_comb begin
    w_ack_clr = 8'h00;
    if (ack && w_valid) w_ack_clr[w_idx] = 1'b1;
  end

  assign w_clr = clr | w_ack_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 8'h00;
      r_ev_prev <= 8'h00;
      r_mask    <= RESET_MASK;
    end else begin
      // Set wins over clear so a coincident new event is never lost.
      r_pending <= w_set | (r_pending & ~w_clr);
      r_ev_prev <= w_ev_s;
      if (mask_we) r_mask <= mask_in;
    end
  end

  assign pending = r_pending;
  assign out     = w_out;
  assign idx     = w_idx;
  assign valid   = w_valid;

endmodule

// File: tb/tb_event_pending8.sv
// Directed bench for event_pending8 (default build: EDGE=1, RESET_MASK=8'hFF, no sync).
module tb_event_pending8;

  logic       clk;
  logic       rst_n;
  logic [7:0] ev;
  logic       mask_we;
  logic [7:0] mask_in;
  logic [7:0] clr;
  logic       ack;
  logic [7:0] pending;
  logic [7:0] out;
  logic [2:0] idx;
  logic       valid;

  int tests_run = 0;
  int fail_cnt  = 0;

  // {pending, out, idx, valid}
  logic [19:0] exp_q[$];

  event_pending8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ev      (ev),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .clr     (clr),
    .ack     (ack),
    .pending (pending),
    .out     (out),
    .idx     (idx),
    .valid   (valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag, input logic [19:0] e);
    check({tag, ".pending"}, pending, e[19:12]);
    check({tag, ".out"},     out,     e[11:4]);
    check({tag, ".idx"},     {5'd0, idx},   {5'd0, e[3:1]});
    check({tag, ".valid"},   {7'd0, valid}, {7'd0, e[0]});
  endtask

  function automatic logic [19:0] pack_exp(input logic [7:0] p, input logic [7:0] o);
    return {p, o, low_idx(o), |o};
  endfunction

  // Driver: apply inputs at negedge, expect (p, o) after the next rising edge.
  task automatic step(input string tag, input logic [7:0] e, input logic [7:0] c,
                      input logic a, input logic mw, input logic [7:0] mi,
                      input logic [7:0] xp, input logic [7:0] xo);
    logic [19:0] got_exp;
    ev = e; clr = c; ack = a; mask_we = mw; mask_in = mi;
    exp_q.push_back(pack_exp(xp, xo));
    @(posedge clk);
    #1;
    got_exp = exp_q.pop_front();
    compare_all(tag, got_exp);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ev = 8'h00; clr = 8'h00; ack = 1'b0; mask_we = 1'b0; mask_in = 8'h00;
    #12;
    compare_all("reset_initial", pack_exp(8'h00, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;

    // T1 edge capture, held level does not re-set after clear
    step("t1_idle",   8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);
    step("t1_rise",   8'h10, 8'h00, 0, 0, 8'h00, 8'h10, 8'h10);
    step("t1_held",   8'h10, 8'h00, 0, 0, 8'h00, 8'h10, 8'h10);
    step("t1_clr",    8'h10, 8'h10, 0, 0, 8'h00, 8'h00, 8'h00);
    step("t1_low",    8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);

    // T2 ack priority walk
    step("t2_set",    8'h26, 8'h00, 0, 0, 8'h00, 8'h26, 8'h26);
    step("t2_ack1",   8'h00, 8'h00, 1, 0, 8'h00, 8'h24, 8'h24);
    step("t2_ack2",   8'h00, 8'h00, 1, 0, 8'h00, 8'h20, 8'h20);
    step("t2_ack5",   8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00);
    step("t2_ackx",   8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00);

    // T3 set beats clear / ack
    step("t3_set",    8'h01, 8'h00, 0, 0, 8'h00, 8'h01, 8'h01);
    step("t3_hold",   8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 8'h01);
    step("t3_setclr", 8'h01, 8'h01, 0, 0, 8'h00, 8'h01, 8'h01);
    step("t3_clr",    8'h01, 8'h01, 0, 0, 8'h00, 8'h00, 8'h00);
    step("t3_set2",   8'h04, 8'h00, 0, 0, 8'h00, 8'h04, 8'h04);
    step("t3_low2",   8'h00, 8'h00, 0, 0, 8'h00, 8'h04, 8'h04);
    step("t3_setack", 8'h04, 8'h00, 1, 0, 8'h00, 8'h04, 8'h04);
    step("t3_ack",    8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00);
    step("t3_clr0",   8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 8'h00);

    // T4 mask
    step("t4_set",    8'h81, 8'h00, 0, 0, 8'h00, 8'h81, 8'h81);
    step("t4_m80",    8'h00, 8'h00, 0, 1, 8'h80, 8'h81, 8'h80);
    step("t4_m00",    8'h00, 8'h00, 0, 1, 8'h00, 8'h81, 8'h00);
    step("t4_ackinv", 8'h00, 8'h00, 1, 0, 8'h00, 8'h81, 8'h00);
    step("t4_mff",    8'h00, 8'h00, 0, 1, 8'hFF, 8'h81, 8'h81);
    step("t4_clrall", 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 8'h00);

    // T0 mid-run async reset, mask restored, held ev counts as edge after release
    step("t0_set",    8'h5A, 8'h00, 0, 0, 8'h00, 8'h5A, 8'h5A);
    step("t0_m00",    8'h5A, 8'h00, 0, 1, 8'h00, 8'h5A, 8'h00);
    ev = 8'h5A; clr = 8'h00; ack = 1'b0; mask_we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    compare_all("t0_async", pack_exp(8'h00, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    step("t0_release", 8'h5A, 8'h00, 0, 0, 8'h00, 8'h5A, 8'h5A);
    step("t0_held",    8'h5A, 8'h00, 0, 0, 8'h00, 8'h5A, 8'h5A);

    // Random clr sweep from all-ones with ev held (no new edges)
    step("rnd_fill",  8'hFF, 8'h00, 0, 0, 8'h00, 8'hFF, 8'hFF);
    begin
      logic [7:0] model;
      logic [7:0] c;
      model = 8'hFF;
      for (int k = 0; k < 6; k++) begin
        c = 8'($urandom_range(0, 255));
        model = model & ~c;
        step($sformatf("rnd_clr%0d", k), 8'hFF, c, 0, 0, 8'h00, model, model);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
